// File: rtl/raster_scan_gen.sv
// Raster/serpentine coordinate generator over a bordered window, with
// ready/valid backpressure, synchronous abort and one-cycle completion pulse.
module raster_scan_gen #(
  parameter int X_W = 10,
  parameter int Y_W = 10
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           start,
  input  logic           abort,
  input  logic [X_W-1:0] img_width,
  input  logic [Y_W-1:0] img_height,
  input  logic [X_W-1:0] border,
  input  logic           serpentine,
  input  logic           pix_ready,
  output logic           pix_valid,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           row_first,
  output logic           row_last,
  output logic           frame_last,
  output logic           busy,
  output logic           frame_done
);

  localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + 1;
  localparam logic [X_W-1:0] X_ONE = {{(X_W-1){1'b0}}, 1'b1};
  localparam logic [Y_W-1:0] Y_ONE = {{(Y_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t         r_state, w_state_next;
  logic [X_W-1:0] r_width, w_width_next;
  logic [Y_W-1:0] r_height, w_height_next;
  logic [X_W-1:0] r_border, w_border_next;
  logic           r_serp, w_serp_next;
  logic           r_rev, w_rev_next;
  logic           r_pix_valid, w_pix_valid_next;
  logic [X_W-1:0] r_pix_x, w_pix_x_next;
  logic [Y_W-1:0] r_pix_y, w_pix_y_next;
  logic           r_row_first, w_row_first_next;
  logic           r_row_last, w_row_last_next;
  logic           r_frame_last, w_frame_last_next;
  logic           r_busy, w_busy_next;
  logic           r_frame_done, w_frame_done_next;

  // While idle the window follows the live inputs so the start edge can
  // decide emptiness and load the first coordinate without an extra cycle.
  logic [X_W-1:0] w_cfg_width;
  logic [Y_W-1:0] w_cfg_height;
  logic [X_W-1:0] w_cfg_border;
  logic           w_cfg_serp;

  assign w_cfg_width  = (r_state == S_IDLE) ? img_width  : r_width;
  assign w_cfg_height = (r_state == S_IDLE) ? img_height : r_height;
  assign w_cfg_border = (r_state == S_IDLE) ? border     : r_border;
  assign w_cfg_serp   = (r_state == S_IDLE) ? serpentine : r_serp;

  // Window bounds carry one guard bit so a border wider than the image
  // shows up as a negative upper bound instead of wrapping.
  logic [X_W:0]   w_x_hi_g;
  logic [CW-1:0]  w_y_lo_g;
  logic [CW-1:0]  w_y_hi_g;
  logic [X_W-1:0] w_x_lo, w_x_hi;
  logic [Y_W-1:0] w_y_lo, w_y_hi;
  logic           w_empty;

  assign w_x_hi_g = {1'b0, w_cfg_width} - {1'b0, w_cfg_border} - {{X_W{1'b0}}, 1'b1};
  assign w_y_lo_g = {{(CW-X_W){1'b0}}, w_cfg_border};
  assign w_y_hi_g = {{(CW-Y_W){1'b0}}, w_cfg_height} - w_y_lo_g - {{(CW-1){1'b0}}, 1'b1};
  assign w_x_lo   = w_cfg_border;
  assign w_x_hi   = w_x_hi_g[X_W-1:0];
  assign w_y_lo   = w_y_lo_g[Y_W-1:0];
  assign w_y_hi   = w_y_hi_g[Y_W-1:0];
  assign w_empty  = w_x_hi_g[X_W] | ({1'b0, w_x_lo} > w_x_hi_g)
                  | w_y_hi_g[CW-1] | (w_y_lo_g > w_y_hi_g);

  // Candidate for the next presented coordinate: first of frame while idle,
  // successor of the current one while scanning.
  logic           w_row_end;
  logic [X_W-1:0] w_cand_x;
  logic [Y_W-1:0] w_cand_y;
  logic           w_cand_rev;
  logic           w_cand_first, w_cand_last, w_cand_flast;

  assign w_row_end = r_rev ? (r_pix_x == w_x_lo) : (r_pix_x == w_x_hi);

  always_comb begin
    w_cand_x   = w_x_lo;
    w_cand_y   = w_y_lo;
    w_cand_rev = 1'b0;
    if (r_state == S_SCAN) begin
      if (w_row_end) begin
        w_cand_rev = w_cfg_serp & ~r_rev;
        w_cand_x   = w_cand_rev ? w_x_hi : w_x_lo;
        w_cand_y   = r_pix_y + Y_ONE;
      end else begin
        w_cand_rev = r_rev;
        w_cand_x   = r_rev ? (r_pix_x - X_ONE) : (r_pix_x + X_ONE);
        w_cand_y   = r_pix_y;
      end
    end
  end

  assign w_cand_first = (w_cand_x == (w_cand_rev ? w_x_hi : w_x_lo));
  assign w_cand_last  = (w_cand_x == (w_cand_rev ? w_x_lo : w_x_hi));
  assign w_cand_flast = w_cand_last & (w_cand_y == w_y_hi);

  always_comb begin
    w_state_next      = r_state;
    w_width_next      = r_width;
    w_height_next     = r_height;
    w_border_next     = r_border;
    w_serp_next       = r_serp;
    w_rev_next        = r_rev;
    w_pix_valid_next  = r_pix_valid;
    w_pix_x_next      = r_pix_x;
    w_pix_y_next      = r_pix_y;
    w_row_first_next  = r_row_first;
    w_row_last_next   = r_row_last;
    w_frame_last_next = r_frame_last;
    w_busy_next       = r_busy;
    w_frame_done_next = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_width_next  = img_width;
          w_height_next = img_height;
          w_border_next = border;
          w_serp_next   = serpentine;
          w_busy_next   = 1'b1;
          if (w_empty) begin
            w_state_next      = S_DONE;
            w_frame_done_next = 1'b1;
          end else begin
            w_state_next      = S_SCAN;
            w_pix_valid_next  = 1'b1;
            w_pix_x_next      = w_cand_x;
            w_pix_y_next      = w_cand_y;
            w_rev_next        = w_cand_rev;
            w_row_first_next  = w_cand_first;
            w_row_last_next   = w_cand_last;
            w_frame_last_next = w_cand_flast;
          end
        end
      end

      S_SCAN: begin
        if (abort) begin
          w_state_next      = S_IDLE;
          w_pix_valid_next  = 1'b0;
          w_row_first_next  = 1'b0;
          w_row_last_next   = 1'b0;
          w_frame_last_next = 1'b0;
          w_busy_next       = 1'b0;
        end else if (r_pix_valid && pix_ready) begin
          if (r_frame_last) begin
            w_state_next      = S_DONE;
            w_pix_valid_next  = 1'b0;
            w_row_first_next  = 1'b0;
            w_row_last_next   = 1'b0;
            w_frame_last_next = 1'b0;
            w_frame_done_next = 1'b1;
          end else begin
            w_pix_x_next      = w_cand_x;
            w_pix_y_next      = w_cand_y;
            w_rev_next        = w_cand_rev;
            w_row_first_next  = w_cand_first;
            w_row_last_next   = w_cand_last;
            w_frame_last_next = w_cand_flast;
          end
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
        w_busy_next  = 1'b0;
      end

      default: begin
        w_state_next      = S_IDLE;
        w_pix_valid_next  = 1'b0;
        w_row_first_next  = 1'b0;
        w_row_last_next   = 1'b0;
        w_frame_last_next = 1'b0;
        w_busy_next       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_width      <= '0;
      r_height     <= '0;
      r_border     <= '0;
      r_serp       <= 1'b0;
      r_rev        <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_row_first  <= 1'b0;
      r_row_last   <= 1'b0;
      r_frame_last <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_width      <= w_width_next;
      r_height     <= w_height_next;
      r_border     <= w_border_next;
      r_serp       <= w_serp_next;
      r_rev        <= w_rev_next;
      r_pix_valid  <= w_pix_valid_next;
      r_pix_x      <= w_pix_x_next;
      r_pix_y      <= w_pix_y_next;
      r_row_first  <= w_row_first_next;
      r_row_last   <= w_row_last_next;
      r_frame_last <= w_frame_last_next;
      r_busy       <= w_busy_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  assign pix_valid  = r_pix_valid;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign row_first  = r_row_first;
  assign row_last   = r_row_last;
  assign frame_last = r_frame_last;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_raster_scan_gen.sv
// Randomized self-checking bench: each frame's coordinate list is built from
// nested row/column loops and matched against the DUT transfer by transfer.
module tb_raster_scan_gen;

  logic       clk;
  logic       n_rst;
  logic       start;
  logic       abort;
  logic [9:0] img_width;
  logic [9:0] img_height;
  logic [9:0] border;
  logic       serpentine;
  logic       pix_ready;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       row_first;
  logic       row_last;
  logic       frame_last;
  logic       busy;
  logic       frame_done;

  int n_checks = 0;
  int n_errors = 0;

  raster_scan_gen #(.X_W(10), .Y_W(10)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .abort      (abort),
    .img_width  (img_width),
    .img_height (img_height),
    .border     (border),
    .serpentine (serpentine),
    .pix_ready  (pix_ready),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .row_first  (row_first),
    .row_last   (row_last),
    .frame_last (frame_last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] all_outputs();
    return {pix_valid, row_first, row_last, frame_last, busy, frame_done,
            pix_y[7:0], pix_x[8:0]} | {3'b0, 10'(pix_y >> 8), 10'(pix_x >> 9)};
  endfunction

  function automatic logic [22:0] coord_obs();
    return {frame_last, row_last, row_first, pix_y, pix_x};
  endfunction

  // Runs one frame from a negedge and returns on a negedge.
  // stall_idx: transfer index held off for 3 cycles; abort_idx: index at which abort fires.
  task automatic run_frame(input int w, input int h, input int b, input bit serp,
                           input int stall_idx, input int abort_idx,
                           input int ready_pct, input bit noise);
    logic [22:0] exp_q[$];
    logic [9:0]  ex, ey;
    int lo, hi, ylo, yhi, idx, stall, cyc;
    bit expect_done, finished;
    lo = b; hi = w - 1 - b; ylo = b; yhi = h - 1 - b;
    for (int y = ylo; y <= yhi; y++) begin
      bit rev;
      rev = serp && (((y - ylo) % 2) == 1);
      for (int k = 0; k <= hi - lo; k++) begin
        int x;
        x = rev ? hi - k : lo + k;
        ex = x[9:0];
        ey = y[9:0];
        exp_q.push_back({(k == hi - lo) && (y == yhi), (k == hi - lo), (k == 0), ey, ex});
      end
    end
    $display("frame w=%0d h=%0d border=%0d serp=%0d coords=%0d abort_idx=%0d",
             w, h, b, serp, exp_q.size(), abort_idx);

    img_width  = w[9:0];
    img_height = h[9:0];
    border     = b[9:0];
    serpentine = serp;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    img_width  = 10'($urandom_range(1023));
    img_height = 10'($urandom_range(1023));
    border     = 10'($urandom_range(1023));
    serpentine = 1'($urandom_range(1));
    check("busy_after_start", 32'(busy), 32'd1);

    idx = 0; stall = 0; cyc = 0; finished = 0;
    expect_done = (exp_q.size() == 0);
    while (!finished && cyc < 4000) begin
      if (expect_done) begin
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("valid_low_in_done", 32'(pix_valid), 32'd0);
        check("busy_in_done", 32'(busy), 32'd1);
        pix_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_done", 32'(busy), 32'd0);
        check("frame_done_single", 32'(frame_done), 32'd0);
        check("valid_after_done", 32'(pix_valid), 32'd0);
        finished = 1;
      end else begin
        check("valid_during_scan", 32'(pix_valid), 32'd1);
        check("coord", 32'(coord_obs()), 32'(exp_q[0]));
        if (idx == abort_idx) begin
          abort = 1'b1;
          start = 1'b1;
          pix_ready = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          start = 1'b0;
          pix_ready = 1'b0;
          check("abort_valid", 32'(pix_valid), 32'd0);
          check("abort_busy", 32'(busy), 32'd0);
          check("abort_no_done", 32'(frame_done), 32'd0);
          @(negedge clk);
          check("abort_no_done_late", 32'(frame_done), 32'd0);
          check("abort_stays_idle", 32'(busy), 32'd0);
          finished = 1;
        end else begin
          if (idx == stall_idx && stall < 3) begin
            pix_ready = 1'b0;
            stall++;
          end else begin
            pix_ready = ($urandom_range(99) < ready_pct);
          end
          start = noise ? 1'($urandom_range(1)) : 1'b0;
          if (pix_ready) begin
            void'(exp_q.pop_front());
            idx++;
            if (exp_q.size() == 0) expect_done = 1;
          end
          @(negedge clk);
          cyc++;
        end
      end
    end
    if (!finished) check("frame_timeout", 32'd0, 32'd1);
    start = 1'b0;
    abort = 1'b0;
    pix_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b0;
    img_width = 10'd0; img_height = 10'd0; border = 10'd0; serpentine = 1'b0;
    #1;
    check("reset_outputs", 32'(all_outputs()), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(busy), 32'd0);

    run_frame(4, 3, 0, 0, -1, -1, 100, 0);  // plain raster
    run_frame(3, 2, 0, 1, -1, -1, 100, 0);  // serpentine
    run_frame(5, 4, 1, 0, -1, -1, 100, 0);  // border
    run_frame(4, 3, 0, 0,  1, -1, 100, 0);  // backpressure on (1,0)
    run_frame(4, 3, 2, 0, -1, -1, 100, 0);  // empty region
    run_frame(4, 3, 0, 0, -1,  6, 100, 0);  // abort at (2,1)
    run_frame(4, 3, 0, 0, -1, -1, 100, 0);  // restart after abort
    run_frame(1, 1, 0, 1, -1, -1, 100, 0);  // single pixel
    run_frame(1, 4, 0, 1, -1, -1, 100, 0);  // single column

    // start with abort in IDLE must not launch a scan
    img_width = 10'd4; img_height = 10'd3; border = 10'd0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 32'({busy, pix_valid, frame_done}), 32'd0);
    @(negedge clk);

    // asynchronous reset in the middle of a frame
    img_width = 10'd6; img_height = 10'd4; border = 10'd0; serpentine = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pix_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 n_rst = 1'b0;
    #1 check("async_reset_outputs", 32'(all_outputs()), 32'd0);
    pix_ready = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 32'({busy, pix_valid}), 32'd0);
    run_frame(6, 4, 0, 1, -1, -1, 100, 0);

    for (int n = 0; n < 30; n++) begin
      int w, h, b, ab, st;
      w  = $urandom_range(12, 1);
      h  = $urandom_range(9, 1);
      b  = $urandom_range(3);
      ab = ($urandom_range(4) == 0) ? $urandom_range(20) : -1;
      st = $urandom_range(8);
      run_frame(w, h, b, 1'($urandom_range(1)), st, ab, 60, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/raster_scan_gen.md
RASTER_SCAN_GEN -- requirements
Module: raster_scan_gen

Interface
REQ-001 Parameter X_W, 10, column-coordinate width in bits.
REQ-002 Parameter Y_W, 10, row-coordinate width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a frame scan; sampled only in IDLE.
REQ-006 abort  input  1  synchronous scan cancel.
REQ-007 img_width  input  X_W  frame width in pixels, legal range 1..2^X_W-1.
REQ-008 img_height  input  Y_W  frame height in pixels, legal range 1..2^Y_W-1.
REQ-009 border  input  X_W  excluded margin on all four sides, in pixels.
REQ-010 serpentine  input  1  0 = every row left-to-right; 1 = alternate rows reversed.
REQ-011 pix_ready  input  1  downstream accepts the current coordinate.
REQ-012 pix_valid  output  1  pix_x/pix_y hold a valid coordinate.
REQ-013 pix_x  output  X_W  column coordinate.
REQ-014 pix_y  output  Y_W  row coordinate.
REQ-015 row_first  output  1  current coordinate is the first one emitted in its row.
REQ-016 row_last  output  1  current coordinate is the last one emitted in its row.
REQ-017 frame_last  output  1  current coordinate is the last one in the frame.
REQ-018 busy  output  1  high in SCAN and DONE.
REQ-019 frame_done  output  1  one-cycle pulse when a scan completes.

Function
REQ-020 FSM states: IDLE, SCAN, DONE; all outputs registered.
REQ-021 In IDLE, start=1 and abort=0 shall latch img_width, img_height, border and serpentine; later input changes shall not affect the scan in progress.
REQ-022 Scan window: x_lo=border, x_hi=img_width-1-border, y_lo=border, y_hi=img_height-1-border, computed with one guard bit so that negative results are detected.
REQ-023 The region is empty if x_lo>x_hi or y_lo>y_hi.
  - Empty region: IDLE->DONE on the start edge; pix_valid shall never assert.
REQ-024 Non-empty region: IDLE->SCAN on the start edge, with the first coordinate loaded and pix_valid=1 in the first cycle after that edge.
REQ-025 Row ordering: row index r=pix_y-y_lo.
  - serpentine=0, or r even: x runs x_lo->x_hi.
  - serpentine=1 and r odd: x runs x_hi->x_lo.
REQ-026 A transfer occurs when pix_valid=1 and pix_ready=1.
  - Only a transfer advances the coordinate.
  - While pix_valid=1 and pix_ready=0, pix_x, pix_y and all flags shall hold stable.
REQ-027 At row end, a transfer shall advance pix_y by 1 and load the starting x of the next row; no bubble cycle.
REQ-028 row_first, row_last and frame_last shall be valid whenever pix_valid=1 and 0 otherwise.
  - Single-column window: row_first and row_last both high.
REQ-029 A transfer with frame_last=1 shall go SCAN->DONE; pix_valid=0 from that edge.
REQ-030 DONE shall last exactly one cycle with frame_done=1, then return to IDLE.
REQ-031 start asserted in SCAN or DONE shall be ignored.
REQ-032 abort=1 in SCAN or DONE shall go to IDLE on the next edge.
  - pix_valid=0 and no frame_done pulse.
  - abort overrides a simultaneous transfer or start.
REQ-033 abort and start together in IDLE: remain in IDLE.
REQ-034 In IDLE and DONE, pix_x and pix_y shall hold their last value; they are don't-care while pix_valid=0.
REQ-035 Coordinate arithmetic shall never wrap: x stays within [x_lo,x_hi] and y within [y_lo,y_hi].

Reset
REQ-036 n_rst=0 shall immediately force the following, regardless of clk: state=IDLE; pix_valid, row_first, row_last, frame_last, busy, frame_done=0; pix_x, pix_y=0; latched configuration=0.
REQ-037 Reset asserted mid-scan shall discard the scan; after release the block idles until a new start.

Verification
REQ-038 Raster, plain: width=4, height=3, border=0, serpentine=0, pix_ready=1.
  - 12 coordinates (0,0)..(3,2) in raster order on consecutive cycles.
  - row_first at x=0, row_last at x=3, frame_last at (3,2).
  - frame_done pulses on the next cycle, busy drops the cycle after.
REQ-039 Serpentine: width=3, height=2, serpentine=1.
  - Sequence (0,0),(1,0),(2,0),(2,1),(1,1),(0,1).
  - row_first at (2,1), row_last at (0,1).
REQ-040 Border: width=5, height=4, border=1.
  - Exactly 6 coordinates: (1,1),(2,1),(3,1),(1,2),(2,2),(3,2).
REQ-041 Backpressure: hold pix_ready=0 for 3 cycles while (1,0) is presented.
  - (1,0) and all flags stay stable.
  - (2,0) follows the cycle after pix_ready returns to 1; no coordinate skipped or duplicated.
REQ-042 Empty region: width=4, border=2.
  - pix_valid never asserts; frame_done=1 in the cycle after start; IDLE the cycle after that.
REQ-043 Abort and reset mid-scan: abort at (2,1) gives pix_valid=0 next cycle and no frame_done.
  - A new start then begins at (x_lo,y_lo).
  - n_rst pulsed mid-frame zeroes all outputs asynchronously.
